// File: rtl/core_types_pkg.sv
// Shared core types for the local-history-table update path:
// queue sizing, field widths, the queued update record and its match rule.
package core_types_pkg;

   localparam int LHT_UQ_ENTRIES     = 4;
   localparam int LOG_LHT_UQ_ENTRIES = $clog2(LHT_UQ_ENTRIES);
   localparam int ASID_WIDTH         = 9;
   localparam int LH_LENGTH          = 8;

   typedef struct packed {
      logic [31:0]           start_full_PC;
      logic [ASID_WIDTH-1:0] ASID;
      logic [LH_LENGTH-1:0]  lh;
   } lht_update_t;

   // Two updates target the same LHT entry when they share fetch-block PC
   // (bit 0 is not part of the block address) and ASID.
   function automatic logic lht_update_match(input lht_update_t a, input lht_update_t b);
      return (a.start_full_PC[31:1] == b.start_full_PC[31:1]) && (a.ASID == b.ASID);
   endfunction

endpackage

// File: rtl/lht_update_queue.sv
// Local-history-table update queue.
// Two resolved-branch updates per cycle enter a circular FIFO; the head entry
// drives the LHT write port and retires every cycle it is valid (no
// backpressure from the table). Updates to the same PC/ASID are coalesced so
// only the newest history is written.
//
// Handshake: an enq port transfers when its valid and enq_ready are both 1 at
// a rising CLK edge; enq_ready depends on occupancy only, so upstream may hold
// valid across not-ready cycles. update0_valid has no ready: a valid head is
// consumed in the cycle it is presented.
module lht_update_queue
   import core_types_pkg::*;
#(
   parameter int LHT_UQ_ENTRIES = core_types_pkg::LHT_UQ_ENTRIES
) (
   input  logic                  CLK,
   input  logic                  nRST,

   input  logic                  enq0_valid,
   input  logic [31:0]           enq0_start_full_PC,
   input  logic [ASID_WIDTH-1:0] enq0_ASID,
   input  logic [LH_LENGTH-1:0]  enq0_lh,

   input  logic                  enq1_valid,
   input  logic [31:0]           enq1_start_full_PC,
   input  logic [ASID_WIDTH-1:0] enq1_ASID,
   input  logic [LH_LENGTH-1:0]  enq1_lh,

   output logic                  enq_ready,

   output logic                  update0_valid,
   output logic [31:0]           update0_start_full_PC,
   output logic [ASID_WIDTH-1:0] update0_ASID,
   output logic [LH_LENGTH-1:0]  update0_lh
);

   localparam int LOG_UQ = $clog2(LHT_UQ_ENTRIES);
   localparam logic [LOG_UQ:0] READY_MAX = (LOG_UQ+1)'(LHT_UQ_ENTRIES - 2);

   typedef logic [LOG_UQ-1:0] ptr_t;
   typedef logic [LOG_UQ:0]   cnt_t;

   lht_update_t                entry_q [LHT_UQ_ENTRIES];
   logic [LHT_UQ_ENTRIES-1:0]  valid_q, valid_d;
   ptr_t                       head_q, head_d;
   ptr_t                       tail_q, tail_d;
   cnt_t                       count_q, count_d;

   lht_update_t enq0_upd, enq1_upd, youngest;
   logic        deq;
   cnt_t        occ_after_deq;
   ptr_t        youngest_idx;
   logic        tail_live;
   logic        acc0, acc1, keep0;
   logic        co0, co1, alloc0, alloc1;
   ptr_t        slot1_idx;

   assign enq0_upd = '{start_full_PC: enq0_start_full_PC, ASID: enq0_ASID, lh: enq0_lh};
   assign enq1_upd = '{start_full_PC: enq1_start_full_PC, ASID: enq1_ASID, lh: enq1_lh};

   // Head presentation: the table write port sees the head entry directly.
   assign update0_valid         = (count_q != '0);
   assign update0_start_full_PC = entry_q[head_q].start_full_PC;
   assign update0_ASID          = entry_q[head_q].ASID;
   assign update0_lh            = entry_q[head_q].lh;

   // Enqueue decisions: acceptance, same-cycle and tail coalescing, allocation.
   always_comb begin
      deq           = (count_q != '0);
      occ_after_deq = count_q - cnt_t'(deq);
      enq_ready     = (occ_after_deq <= READY_MAX);

      youngest_idx  = tail_q - ptr_t'(1);
      youngest      = entry_q[youngest_idx];
      // The youngest entry may only absorb an update if it is not the one
      // retiring this cycle.
      tail_live     = (count_q >= cnt_t'(2));

      acc0   = enq0_valid & enq_ready;
      acc1   = enq1_valid & enq_ready;
      // A matching younger update supersedes port 0 outright.
      keep0  = acc0 & ~(acc1 & lht_update_match(enq0_upd, enq1_upd));
      co0    = keep0 & tail_live & lht_update_match(enq0_upd, youngest);
      alloc0 = keep0 & ~co0;
      // If port 0 allocated, port 1 is known not to match it, so port 1 can
      // only fold into the older tail when port 0 did not allocate.
      co1    = acc1 & ~alloc0 & tail_live & lht_update_match(enq1_upd, youngest);
      alloc1 = acc1 & ~co1;

      slot1_idx = alloc0 ? (tail_q + ptr_t'(1)) : tail_q;

      head_d  = head_q + ptr_t'(deq);
      tail_d  = tail_q + ptr_t'(alloc0) + ptr_t'(alloc1);
      count_d = count_q - cnt_t'(deq) + cnt_t'(alloc0) + cnt_t'(alloc1);

      valid_d = valid_q;
      if (deq)    valid_d[head_q]    = 1'b0;
      if (alloc0) valid_d[tail_q]    = 1'b1;
      if (alloc1) valid_d[slot1_idx] = 1'b1;
   end

   // Pointer, occupancy and entry-valid state; reset discards everything.
   always_ff @(posedge CLK) begin
      if (nRST) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   // Entry payload writes; payload is meaningless until its valid bit is set.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         if (alloc0) entry_q[tail_q]    <= enq0_upd;
         if (alloc1) entry_q[slot1_idx] <= enq1_upd;
         if (co1)      entry_q[youngest_idx].lh <= enq1_lh;
         else if (co0) entry_q[youngest_idx].lh <= enq0_lh;
      end
   end

   // Occupancy can never exceed the depth because enq_ready reserves two slots.
   a_no_overflow : assert property (@(posedge CLK) disable iff (nRST)
      count_q <= cnt_t'(LHT_UQ_ENTRIES));

   // Any non-empty queue must present a valid head entry.
   a_head_valid : assert property (@(posedge CLK) disable iff (nRST)
      (count_q != '0) |-> valid_q[head_q]);

endmodule

// File: tb/tb_lht_update_queue.sv
// Bench for lht_update_queue: directed scenarios followed by random traffic,
// checked against a queue-of-updates reference model.
module tb_lht_update_queue;
   import core_types_pkg::*;

   localparam int N = LHT_UQ_ENTRIES;
   localparam int W = 32 + ASID_WIDTH + LH_LENGTH;

   logic                  CLK = 1'b0;
   logic                  nRST = 1'b1;
   logic                  enq0_valid = 1'b0, enq1_valid = 1'b0;
   logic [31:0]           enq0_start_full_PC = '0, enq1_start_full_PC = '0;
   logic [ASID_WIDTH-1:0] enq0_ASID = '0, enq1_ASID = '0;
   logic [LH_LENGTH-1:0]  enq0_lh = '0, enq1_lh = '0;
   logic                  enq_ready;
   logic                  update0_valid;
   logic [31:0]           update0_start_full_PC;
   logic [ASID_WIDTH-1:0] update0_ASID;
   logic [LH_LENGTH-1:0]  update0_lh;

   int tests_run = 0;
   int tests_failed = 0;
   bit started = 0;

   // Expected head-of-table writes, oldest first, packed as {PC, ASID, lh}.
   logic [W-1:0] exp_q[$];

   lht_update_queue #(.LHT_UQ_ENTRIES(N)) dut (
      .CLK(CLK), .nRST(nRST),
      .enq0_valid(enq0_valid), .enq0_start_full_PC(enq0_start_full_PC),
      .enq0_ASID(enq0_ASID), .enq0_lh(enq0_lh),
      .enq1_valid(enq1_valid), .enq1_start_full_PC(enq1_start_full_PC),
      .enq1_ASID(enq1_ASID), .enq1_lh(enq1_lh),
      .enq_ready(enq_ready),
      .update0_valid(update0_valid), .update0_start_full_PC(update0_start_full_PC),
      .update0_ASID(update0_ASID), .update0_lh(update0_lh)
   );

   // Clock
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic same_target(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [31:0] pa, pb;
      logic [ASID_WIDTH-1:0] sa, sb;
      {pa, sa} = a[W-1:LH_LENGTH];
      {pb, sb} = b[W-1:LH_LENGTH];
      return (pa[31:1] == pb[31:1]) && (sa == sb);
   endfunction

   // Reference model: at each edge, drop everything on reset, otherwise fold
   // accepted updates into the pending list. The monitor has already removed
   // the entry retiring this cycle, so exp_q holds exactly what stays.
   always @(posedge CLK) begin
      logic [W-1:0] u0, u1;
      bit ready, fresh;
      if (nRST) begin
         exp_q.delete();
         started = 1;
      end else if (started) begin
         u0 = {enq0_start_full_PC, enq0_ASID, enq0_lh};
         u1 = {enq1_start_full_PC, enq1_ASID, enq1_lh};
         ready = (exp_q.size() <= N - 2);
         fresh = 0;
         if (ready && enq0_valid) begin
            if (exp_q.size() >= 1 && same_target(u0, exp_q[$]))
               exp_q[$][LH_LENGTH-1:0] = enq0_lh;
            else begin
               exp_q.push_back(u0);
               fresh = 1;
            end
         end
         if (ready && enq1_valid) begin
            if (fresh && same_target(u1, exp_q[$]))
               exp_q[$] = u1;
            else if (exp_q.size() >= 1 && same_target(u1, exp_q[$]))
               exp_q[$][LH_LENGTH-1:0] = enq1_lh;
            else
               exp_q.push_back(u1);
         end
      end
   end

   // Monitor: compare the presented head against the oldest expected update.
   always @(negedge CLK) begin
      int sz;
      logic [W-1:0] e;
      if (started) begin
         sz = exp_q.size();
         check("enq_ready", 64'(enq_ready), 64'((sz == 0 ? 0 : sz - 1) <= N - 2));
         check("update0_valid", 64'(update0_valid), 64'(sz != 0));
         if (sz != 0) begin
            e = exp_q.pop_front();
            if (update0_valid) begin
               check("update0_PC",   64'(update0_start_full_PC), 64'(e[W-1 -: 32]));
               check("update0_ASID", 64'(update0_ASID), 64'(e[LH_LENGTH +: ASID_WIDTH]));
               check("update0_lh",   64'(update0_lh), 64'(e[LH_LENGTH-1:0]));
            end
         end
      end
   end

   // Driver: apply one cycle of inputs shortly after the rising edge.
   task automatic drive(input logic rst,
                        input logic v0, input logic [31:0] pc0, input int as0, input int lh0,
                        input logic v1, input logic [31:0] pc1, input int as1, input int lh1);
      @(posedge CLK);
      #2;
      nRST               = rst;
      enq0_valid         = v0;
      enq0_start_full_PC = pc0;
      enq0_ASID          = ASID_WIDTH'(as0);
      enq0_lh            = LH_LENGTH'(lh0);
      enq1_valid         = v1;
      enq1_start_full_PC = pc1;
      enq1_ASID          = ASID_WIDTH'(as1);
      enq1_lh            = LH_LENGTH'(lh1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Single update on an empty queue, then the queue empties again.
      drive(0, 1, 32'h1000, 1, 'hA5, 0, 0, 0, 0);
      idle(3);

      // Both ports every cycle with distinct PCs until enq_ready drops.
      for (int k = 0; k < 6; k++)
         drive(0, 1, 32'h100 * (2*k+1), 1, k, 1, 32'h100 * (2*k+2), 1, 16 + k);
      idle(8);

      // Same-cycle coalesce.
      drive(0, 1, 32'h2000, 1, 'h01, 1, 32'h2000, 1, 'h03);
      idle(3);

      // Tail coalesce into a held entry.
      drive(0, 1, 32'h3100, 1, 'h11, 1, 32'h3200, 1, 'h22);
      drive(0, 1, 32'h3300, 1, 'h33, 1, 32'h3000, 1, 'h44);
      drive(0, 1, 32'h3000, 1, 'h7F, 0, 0, 0, 0);
      idle(6);

      // Same PC, different ASID stays two writes.
      drive(0, 1, 32'h5000, 1, 'h0A, 1, 32'h5000, 2, 'h0B);
      idle(4);

      // Reset with a full queue and enqueues pending.
      drive(0, 1, 32'h6000, 1, 1, 1, 32'h6100, 1, 2);
      drive(0, 1, 32'h6200, 1, 3, 1, 32'h6300, 1, 4);
      drive(0, 1, 32'h6400, 1, 5, 1, 32'h6500, 1, 6);
      drive(1, 1, 32'h6600, 1, 7, 1, 32'h6700, 1, 8);
      idle(4);

      // Random traffic over a small PC/ASID set so coalescing is frequent.
      for (int c = 0; c < 500; c++) begin
         logic [31:0] p0, p1;
         p0 = 32'h4000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 1));
         p1 = 32'h4000 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 1));
         drive(logic'($urandom_range(0, 59) == 0),
               logic'($urandom_range(0, 2) != 0), p0, $urandom_range(1, 2), $urandom_range(0, 255),
               logic'($urandom_range(0, 2) != 0), p1, $urandom_range(1, 2), $urandom_range(0, 255));
      end
      idle(10);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/lht_update_queue.md
LHT_UPDATE_QUEUE -- requirements
Module: lht_update_queue

Interface
REQ-001 Parameter: LHT_UQ_ENTRIES, 4, queue depth (power of 2, >=4).
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset; synchronous, active-high (asserted = 1).
REQ-004 enq0_valid  input  1  older resolved-branch LH update present.
REQ-005 enq0_start_full_PC  input  32  fetch-block start PC of update 0.
REQ-006 enq0_ASID  input  ASID_WIDTH  ASID of update 0.
REQ-007 enq0_lh  input  LH_LENGTH  new local history (already shifted) for update 0.
REQ-008 enq1_valid / enq1_start_full_PC / enq1_ASID / enq1_lh  input  1/32/ASID_WIDTH/LH_LENGTH  younger update, same meanings.
REQ-009 enq_ready  output  1  queue can accept both enq ports this cycle.
REQ-010 update0_valid  output  1  head entry valid; drives LHT write port.
REQ-011 update0_start_full_PC  output  32  head PC.
REQ-012 update0_ASID  output  ASID_WIDTH  head ASID.
REQ-013 update0_lh  output  LH_LENGTH  head local history.

Function
REQ-014 Queue is circular FIFO: head ptr, tail ptr, occupancy count 0..LHT_UQ_ENTRIES; pointers wrap modulo LHT_UQ_ENTRIES.
REQ-015 Outputs update0_* are driven combinationally from head entry registers; update0_valid = (count != 0).
REQ-016 Dequeue is unconditional: every cycle count != 0, head entry retires and head ptr advances (LHT write has no backpressure).
REQ-017 enq_ready = (free entries after this cycle's dequeue) >= 2, i.e. count - (count!=0) <= LHT_UQ_ENTRIES-2; combinational from count only.
REQ-018 An enq port is accepted only when its valid and enq_ready are both 1; with enq_ready = 0 both ports are dropped (upstream holds).
REQ-019 Match = equal start_full_PC[31:1] and equal ASID.
REQ-020 Same-cycle coalesce: both ports accepted and matching -> only port 1 allocates; port 0 discarded.
REQ-021 Tail coalesce: an accepted port matching the youngest valid entry, when count >= 2 (youngest not retiring this cycle), overwrites that entry's lh instead of allocating.
REQ-022 Tail coalesce applies to port 0 before port 1; if port 0 allocates, port 1 coalesce checks against port 0's new entry (per REQ-020), never the older tail.
REQ-023 Allocation order preserved: port 0 entry written at tail, port 1 at tail+1 (or tail if port 0 coalesced/invalid); tail advances by allocations.
REQ-024 Enqueue-to-update0 latency = 1 cycle when queue empty; else after all older entries retire.
REQ-025 Simultaneous dequeue and enqueue: count_next = count - deq + alloc; full-drain with enqueue never loses entries.
REQ-026 count never exceeds LHT_UQ_ENTRIES; overflow is impossible by REQ-017 and is an assertion failure.

Reset
REQ-027 nRST = 1 at a clock edge: count = 0, head = tail = 0, all entry valid = 0; update0_valid = 0 next cycle.
REQ-028 Entry payload (PC/ASID/lh) need not be reset; update0_start_full_PC/ASID/lh are don't-care while update0_valid = 0.
REQ-029 Reset mid-operation discards all queued updates; enqueues presented in the reset cycle are dropped.
REQ-030 enq_ready = 1 in the first cycle after reset.

Structure
REQ-031 LHT_UQ_ENTRIES, LOG_LHT_UQ_ENTRIES and an lht_update_t struct (start_full_PC, ASID, lh) belong in core_types_pkg.
REQ-032 Single module, no sub-modules; update0_* ports connect directly to lht update0 ports.

Verification
REQ-033 Reset, enq0 PC=0x1000 ASID=1 lh=0xA5 -> next cycle update0_valid=1, PC=0x1000, lh=0xA5; following cycle update0_valid=0.
REQ-034 Both ports valid each cycle, distinct PCs, 6 cycles -> enq_ready drops to 0 when 3 entries held after dequeue; all accepted updates appear on update0 in order, none lost or duplicated.
REQ-035 Same cycle enq0 PC=0x2000 lh=0x01, enq1 PC=0x2000 lh=0x03, same ASID -> exactly one update0 with lh=0x03.
REQ-036 Queue holds 3 entries, youngest PC=0x3000; enq0 PC=0x3000 lh=0x7F -> count unchanged minus dequeue; youngest retires later with lh=0x7F.
REQ-037 Same PC different ASID (1 vs 2) on both ports -> two separate update0 writes, ASID 1 then 2.
REQ-038 nRST asserted with 4 entries queued and enq valid -> next cycle update0_valid=0, enq_ready=1, no queued update ever emitted.
